// File: rtl/lfsr_pkg.sv
// Shared constants for the 4-bit Fibonacci LFSR: width, reset state and feedback taps.
package lfsr_pkg;

  localparam int LFSR_WIDTH = 4;

  typedef logic [LFSR_WIDTH-1:0] lfsr_word_t;

  localparam lfsr_word_t LFSR_RESET = 4'hF;

  // Feedback taps for x^4+x^3+1 in right-shift form: f = w[1] ^ w[0]
  localparam int TAP_A = 0;
  localparam int TAP_B = 1;

endpackage

// File: rtl/lfsr_4bit_if.sv
// Load/observe bus of the LFSR: the master drives seed and sel, the LFSR drives w.
interface lfsr_4bit_if;
  import lfsr_pkg::*;

  lfsr_word_t seed;
  logic       sel;
  lfsr_word_t w;

  modport master (output seed, output sel, input w);
  modport slave  (input seed, input sel, output w);

endinterface

// File: rtl/lfsr_cell.sv
// One LFSR bit: selects parallel-load or shift input, registered with synchronous reset.
module lfsr_cell #(
  parameter logic RESET_BIT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic sel,
  input  logic seed_bit,
  input  logic shift_in,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RESET_BIT;
    end else begin
      q <= sel ? seed_bit : shift_in;
    end
  end

endmodule

// File: rtl/lfsr_4bit.sv
// Maximal-length 4-bit Fibonacci LFSR (period 15) with synchronous seed load.
module lfsr_4bit
  import lfsr_pkg::*;
#(
  parameter int                 WIDTH       = LFSR_WIDTH,
  parameter logic [WIDTH-1:0]   RESET_VALUE = LFSR_RESET
) (
  input  logic       clk,
  input  logic       rst,
  lfsr_4bit_if.slave bus
);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] shift_vec;
  logic             feedback;

  assign feedback  = state[TAP_B] ^ state[TAP_A];
  // Right shift: feedback enters at the MSB, bit 0 falls off the end
  assign shift_vec = {feedback, state[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    lfsr_cell #(
      .RESET_BIT (RESET_VALUE[i])
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .sel      (bus.sel),
      .seed_bit (bus.seed[i]),
      .shift_in (shift_vec[i]),
      .q        (state[i])
    );
  end

  assign bus.w = state;

endmodule

// File: tb/tb_lfsr_4bit.sv
// Scoreboard bench for lfsr_4bit: directed vectors push expected w, a monitor pops and compares.
module tb_lfsr_4bit;
  import lfsr_pkg::*;

  typedef struct {
    logic [3:0] w;
    string      name;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  // Hand-written maximal sequence starting from 1111
  logic [3:0] seq [15] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                           4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE};

  lfsr_4bit_if bus ();

  lfsr_4bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic applyStimulus(input logic r, input logic s, input logic [3:0] sd,
                               input logic [3:0] expw, input string name);
    exp_t e;
    @(negedge clk);
    rst      = r;
    bus.sel  = s;
    bus.seed = sd;
    e.w      = expw;
    e.name   = name;
    sb.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    checks++;
    if (bus.w !== e.w) begin
      errors++;
      $display("[TB] FAIL %s: w=%b expected=%b at %0t", e.name, bus.w, e.w, $time);
    end
  endtask

  // Monitor: w is valid every cycle, so one expectation is retired per edge
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      checkOutput(sb.pop_front());
    end
  end

  initial begin
    int k;
    int waited;
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    bus.sel  = 1'b0;
    bus.seed = 4'h0;

    applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, "reset");
    applyStimulus(1'b1, 1'b1, 4'h5, 4'hF, "reset_ignores_load");

    for (int n = 1; n <= 15; n++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, seq[n % 15], "free_run");
    end

    applyStimulus(1'b0, 1'b1, 4'hA, 4'hA, "load_1010");
    applyStimulus(1'b0, 1'b0, 4'hA, 4'hD, "shift_after_load_1");
    applyStimulus(1'b0, 1'b0, 4'hA, 4'hE, "shift_after_load_2");

    applyStimulus(1'b0, 1'b1, 4'h3, 4'h3, "hold_load_a");
    applyStimulus(1'b0, 1'b1, 4'h9, 4'h9, "hold_load_b");
    applyStimulus(1'b0, 1'b0, 4'h9, 4'hC, "shift_after_hold");

    applyStimulus(1'b0, 1'b1, 4'h0, 4'h0, "load_zero");
    for (int n = 0; n < 5; n++) begin
      applyStimulus(1'b0, 1'b0, 4'h0, 4'h0, "lockup");
    end
    applyStimulus(1'b1, 1'b0, 4'h0, 4'hF, "lockup_reset");

    applyStimulus(1'b0, 1'b0, 4'h0, 4'h7, "mid_shift_1");
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h3, "mid_shift_2");
    applyStimulus(1'b0, 1'b0, 4'h0, 4'h1, "mid_shift_3");
    applyStimulus(1'b1, 1'b1, 4'h6, 4'hF, "mid_reset_wins");

    // Period: every nonzero seed walks the table and lands back on itself after 15 shifts
    for (int s = 1; s < 16; s++) begin
      k = 0;
      for (int j = 0; j < 15; j++) begin
        if (seq[j] == 4'(s)) k = j;
      end
      applyStimulus(1'b0, 1'b1, 4'(s), 4'(s), "period_load");
      for (int n = 1; n <= 15; n++) begin
        applyStimulus(1'b0, 1'b0, 4'h0, seq[(k + n) % 15],
                      (n == 15) ? "period_return" : "period_step");
      end
    end

    waited = 0;
    while (sb.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
